piece_bounds_tracker: RTL and testbench

//  Owns the falling piece: shape, rotation and cell position in the playfield.

---
 rtl/tetris_pkg.sv | 32 +++
 rtl/piece_dims.sv | 31 +++
 rtl/piece_bounds_tracker.sv | 216 +++++++++++++++++++++
 tb/tb_piece_bounds_tracker.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types for the falling-piece logic: command opcodes, shape codes, tracker states.
// Latency: n/a (types only).
// Backpressure: n/a.
package tetris_pkg;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_SPAWN   = 3'd1,
        CMD_LEFT    = 3'd2,
        CMD_RIGHT   = 3'd3,
        CMD_DOWN    = 3'd4,
        CMD_ROT_CW  = 3'd5,
        CMD_ROT_CCW = 3'd6,
        CMD_CLEAR   = 3'd7
    } piece_cmd_e;

    localparam logic [2:0] SHAPE_NONE = 3'd0;
    localparam logic [2:0] SHAPE_I    = 3'd1;
    localparam logic [2:0] SHAPE_O    = 3'd2;
    localparam logic [2:0] SHAPE_T    = 3'd3;
    localparam logic [2:0] SHAPE_S    = 3'd4;
    localparam logic [2:0] SHAPE_Z    = 3'd5;
    localparam logic [2:0] SHAPE_J    = 3'd6;
    localparam logic [2:0] SHAPE_L    = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_CHECK  = 2'd2
    } piece_state_e;

endpackage

// File: rtl/piece_dims.sv
// Bounding box of a shape at a given rotation, in cells.
// Latency: combinational.
// Backpressure: none.
module piece_dims
    import tetris_pkg::*;
(
    input  logic [2:0] shape,
    input  logic [1:0] rot,
    output logic [2:0] w_cells,
    output logic [2:0] h_cells
);

    logic upright;
    assign upright = (rot == 2'd1) || (rot == 2'd3);

    always_comb begin
        w_cells = 3'd0;
        h_cells = 3'd0;
        if (shape == SHAPE_I) begin
            w_cells = upright ? 3'd1 : 3'd4;
            h_cells = upright ? 3'd4 : 3'd1;
        end else if (shape == SHAPE_O) begin
            w_cells = 3'd2;
            h_cells = 3'd2;
        end else if (shape != SHAPE_NONE) begin
            w_cells = upright ? 3'd2 : 3'd3;
            h_cells = upright ? 3'd3 : 3'd2;
        end
    end

endmodule

// File: rtl/piece_bounds_tracker.sv
// Holds the falling piece, range-checks move/rotate/spawn commands against the field edges.
// Latency: command accepted at edge k, state and response strobe update at edge k+1.
// Backpressure: cmd_ready low for the single check cycle; one command per 2 cycles, nothing queued.
module piece_bounds_tracker
    import tetris_pkg::*;
#(
    parameter int CELL_PX = 16,
    parameter int FIELD_W = 10,
    parameter int FIELD_H = 20,
    parameter int PIX_W   = 10,
    parameter int SPAWN_X = 3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [2:0]       cmd_shape,
    output logic             rsp_valid,
    output logic             rsp_ok,
    output logic             landed,
    output logic             active,
    output logic [2:0]       shape_num,
    output logic [1:0]       shape_rot,
    output logic [PIX_W-1:0] pos_x_px,
    output logic [PIX_W-1:0] pos_y_px,
    output logic [PIX_W-1:0] shape_size_x,
    output logic [PIX_W-1:0] shape_size_y
);

    localparam int CW = $clog2(FIELD_H) + 1;
    localparam logic [CW-1:0] FW = CW'(FIELD_W);
    localparam logic [CW-1:0] FH = CW'(FIELD_H);
    localparam logic [CW-1:0] SX = CW'(SPAWN_X);

    piece_state_e   state;
    piece_cmd_e     op_q;
    logic [2:0]     pend_shape;
    logic [CW-1:0]  cell_x;
    logic [CW-1:0]  cell_y;

    logic [2:0]     cand_shape;
    logic [1:0]     cand_rot;
    logic [2:0]     cur_w, cur_h, cand_w, cand_h;

    piece_dims u_cur_dims (
        .shape   (shape_num),
        .rot     (shape_rot),
        .w_cells (cur_w),
        .h_cells (cur_h)
    );

    piece_dims u_cand_dims (
        .shape   (cand_shape),
        .rot     (cand_rot),
        .w_cells (cand_w),
        .h_cells (cand_h)
    );

    always_comb begin
        cand_shape = shape_num;
        cand_rot   = shape_rot;
        case (op_q)
            CMD_SPAWN: begin
                cand_shape = pend_shape;
                cand_rot   = 2'd0;
            end
            CMD_ROT_CW:  cand_rot = shape_rot + 2'd1;
            CMD_ROT_CCW: cand_rot = shape_rot - 2'd1;
            default: ;
        endcase
    end

    logic [CW-1:0] cw_c, ch_c, kw_c, kh_c;
    assign cw_c = CW'(cur_w);
    assign ch_c = CW'(cur_h);
    assign kw_c = CW'(cand_w);
    assign kh_c = CW'(cand_h);

    logic          is_active, commit_ok, land, to_empty;
    logic [2:0]    nshape;
    logic [1:0]    nrot;
    logic [CW-1:0] nx, ny;
    logic [2:0]    nw, nh;

    always_comb begin
        is_active = (shape_num != SHAPE_NONE);
        commit_ok = 1'b0;
        land      = 1'b0;
        to_empty  = 1'b0;
        nshape    = shape_num;
        nrot      = shape_rot;
        nx        = cell_x;
        ny        = cell_y;
        nw        = cur_w;
        nh        = cur_h;
        case (op_q)
            CMD_NOP: commit_ok = 1'b1;
            CMD_SPAWN: begin
                if (!is_active && pend_shape != SHAPE_NONE) begin
                    commit_ok = 1'b1;
                    nshape    = pend_shape;
                    nrot      = 2'd0;
                    ny        = '0;
                    nx        = (SX < FW - kw_c) ? SX : FW - kw_c;
                    nw        = cand_w;
                    nh        = cand_h;
                end
            end
            CMD_LEFT: begin
                if (is_active && cell_x != '0) begin
                    commit_ok = 1'b1;
                    nx        = cell_x - 1'b1;
                end
            end
            CMD_RIGHT: begin
                if (is_active && (cell_x + cw_c) < FW) begin
                    commit_ok = 1'b1;
                    nx        = cell_x + 1'b1;
                end
            end
            CMD_DOWN: begin
                if (is_active) begin
                    if ((cell_y + ch_c) < FH) begin
                        commit_ok = 1'b1;
                        ny        = cell_y + 1'b1;
                    end else begin
                        land     = 1'b1;
                        to_empty = 1'b1;
                    end
                end
            end
            CMD_ROT_CW, CMD_ROT_CCW: begin
                // Anchor stays top-left; only the right wall kicks, the floor rejects.
                if (is_active && (cell_y + kh_c) <= FH) begin
                    commit_ok = 1'b1;
                    nrot      = cand_rot;
                    nw        = cand_w;
                    nh        = cand_h;
                    if ((cell_x + kw_c) > FW)
                        nx = FW - kw_c;
                end
            end
            CMD_CLEAR: begin
                commit_ok = 1'b1;
                to_empty  = 1'b1;
            end
            default: ;
        endcase
        if (to_empty) begin
            nshape = SHAPE_NONE;
            nrot   = 2'd0;
            nx     = '0;
            ny     = '0;
            nw     = 3'd0;
            nh     = 3'd0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= ST_EMPTY;
            op_q         <= CMD_NOP;
            pend_shape   <= SHAPE_NONE;
            cell_x       <= '0;
            cell_y       <= '0;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_ok       <= 1'b0;
            landed       <= 1'b0;
            active       <= 1'b0;
            shape_num    <= SHAPE_NONE;
            shape_rot    <= 2'd0;
            pos_x_px     <= '0;
            pos_y_px     <= '0;
            shape_size_x <= '0;
            shape_size_y <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_ok    <= 1'b0;
            landed    <= 1'b0;
            case (state)
                ST_EMPTY, ST_ACTIVE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q       <= piece_cmd_e'(cmd_op);
                        pend_shape <= cmd_shape;
                        cmd_ready  <= 1'b0;
                        state      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // Rejected commands leave n* equal to the current state, so writing back is safe.
                    rsp_valid    <= 1'b1;
                    rsp_ok       <= commit_ok;
                    landed       <= land;
                    shape_num    <= nshape;
                    shape_rot    <= nrot;
                    cell_x       <= nx;
                    cell_y       <= ny;
                    active       <= (nshape != SHAPE_NONE);
                    state        <= (nshape != SHAPE_NONE) ? ST_ACTIVE : ST_EMPTY;
                    cmd_ready    <= 1'b1;
                    pos_x_px     <= PIX_W'(32'(nx) * CELL_PX);
                    pos_y_px     <= PIX_W'(32'(ny) * CELL_PX);
                    shape_size_x <= PIX_W'(32'(nw) * CELL_PX);
                    shape_size_y <= PIX_W'(32'(nh) * CELL_PX);
                end
                default: begin
                    state     <= ST_EMPTY;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_bounds_tracker.sv
// Directed bench for piece_bounds_tracker: spawn, moves, rotation kick, landing, illegal ops, reset abort.
module tb_piece_bounds_tracker;
    import tetris_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [2:0] cmd_shape = 3'd0;
    logic       rsp_valid, rsp_ok, landed, active;
    logic [2:0] shape_num;
    logic [1:0] shape_rot;
    logic [9:0] pos_x_px, pos_y_px, shape_size_x, shape_size_y;

    int n_checks = 0;
    int n_pass = 0;
    logic r_vld, r_ok, r_land, r_rdy_chk;

    piece_bounds_tracker dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_shape(cmd_shape),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .landed(landed), .active(active),
        .shape_num(shape_num), .shape_rot(shape_rot),
        .pos_x_px(pos_x_px), .pos_y_px(pos_y_px),
        .shape_size_x(shape_size_x), .shape_size_y(shape_size_y)
    );

    always #5 Clk = ~Clk;

    // Issue one command and capture the response one edge after acceptance.
    task automatic do_cmd(input logic [2:0] op, input logic [2:0] shp);
        @(negedge Clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_shape = shp;
        @(posedge Clk); #1;
        cmd_valid = 1'b0;
        r_rdy_chk = cmd_ready;
        @(posedge Clk); #1;
        r_vld = rsp_valid; r_ok = rsp_ok; r_land = landed;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready); else n_pass++;
        n_checks++; if ({rsp_valid, rsp_ok, landed, active} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {rsp_valid, rsp_ok, landed, active}); else n_pass++;
        n_checks++; if ({shape_num, shape_rot, pos_x_px, pos_y_px, shape_size_x, shape_size_y} !== 45'd0) $display("FAIL reset_outputs got %h want 0", {shape_num, shape_rot, pos_x_px, pos_y_px, shape_size_x, shape_size_y}); else n_pass++;
        @(negedge Clk); Reset_n = 1'b1;
    endtask

    task automatic test_spawn();
        do_cmd(CMD_SPAWN, SHAPE_I);
        n_checks++; if (r_rdy_chk !== 1'b0) $display("FAIL spawn_ready_in_check got %b want 0", r_rdy_chk); else n_pass++;
        n_checks++; if ({r_vld, r_ok} !== 2'b11) $display("FAIL spawn_rsp got %b want 11", {r_vld, r_ok}); else n_pass++;
        n_checks++; if (pos_x_px !== 10'd48 || pos_y_px !== 10'd0) $display("FAIL spawn_pos got (%0d,%0d) want (48,0)", pos_x_px, pos_y_px); else n_pass++;
        n_checks++; if (shape_size_x !== 10'd64 || shape_size_y !== 10'd16) $display("FAIL spawn_size got (%0d,%0d) want (64,16)", shape_size_x, shape_size_y); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1 || active !== 1'b1) $display("FAIL spawn_after got ready=%b active=%b want 1 1", cmd_ready, active); else n_pass++;
    endtask

    task automatic test_right_edge();
        for (int i = 0; i < 7; i++) begin
            do_cmd(CMD_RIGHT, 3'd0);
            n_checks++; if (r_vld !== 1'b1 || r_ok !== (i < 3)) $display("FAIL right_%0d got vld=%b ok=%b want 1 %b", i, r_vld, r_ok, (i < 3)); else n_pass++;
        end
        n_checks++; if (pos_x_px !== 10'd96) $display("FAIL right_pos got %0d want 96", pos_x_px); else n_pass++;
    endtask

    task automatic test_rotate_kick();
        do_cmd(CMD_ROT_CW, 3'd0);
        n_checks++; if (r_ok !== 1'b1 || shape_rot !== 2'd1) $display("FAIL rotcw got ok=%b rot=%0d want 1 1", r_ok, shape_rot); else n_pass++;
        n_checks++; if (shape_size_x !== 10'd16 || shape_size_y !== 10'd64 || pos_x_px !== 10'd96) $display("FAIL rotcw_box got (%0d,%0d) x=%0d want (16,64) x=96", shape_size_x, shape_size_y, pos_x_px); else n_pass++;
        repeat (3) do_cmd(CMD_RIGHT, 3'd0);
        n_checks++; if (pos_x_px !== 10'd144) $display("FAIL upright_right got %0d want 144", pos_x_px); else n_pass++;
        do_cmd(CMD_ROT_CCW, 3'd0);
        n_checks++; if (r_ok !== 1'b1 || shape_rot !== 2'd0 || pos_x_px !== 10'd96) $display("FAIL kick got ok=%b rot=%0d x=%0d want 1 0 96", r_ok, shape_rot, pos_x_px); else n_pass++;
        n_checks++; if (shape_size_x !== 10'd64 || shape_size_y !== 10'd16) $display("FAIL kick_size got (%0d,%0d) want (64,16)", shape_size_x, shape_size_y); else n_pass++;
    endtask

    task automatic test_drop_land();
        int oks;
        do_cmd(CMD_CLEAR, 3'd0);
        n_checks++; if (r_ok !== 1'b1 || active !== 1'b0 || shape_num !== 3'd0) $display("FAIL clear got ok=%b active=%b shape=%0d want 1 0 0", r_ok, active, shape_num); else n_pass++;
        do_cmd(CMD_SPAWN, SHAPE_O);
        n_checks++; if (r_ok !== 1'b1 || pos_x_px !== 10'd48 || shape_size_x !== 10'd32 || shape_size_y !== 10'd32) $display("FAIL spawn_o got ok=%b x=%0d size=(%0d,%0d) want 1 48 (32,32)", r_ok, pos_x_px, shape_size_x, shape_size_y); else n_pass++;
        oks = 0;
        for (int i = 0; i < 18; i++) begin
            do_cmd(CMD_DOWN, 3'd0);
            if (r_ok === 1'b1 && r_land === 1'b0) oks++;
        end
        n_checks++; if (oks != 18 || pos_y_px !== 10'd288) $display("FAIL drop got oks=%0d y=%0d want 18 288", oks, pos_y_px); else n_pass++;
        do_cmd(CMD_DOWN, 3'd0);
        n_checks++; if ({r_vld, r_ok, r_land} !== 3'b101) $display("FAIL land_rsp got vld/ok/landed=%b want 101", {r_vld, r_ok, r_land}); else n_pass++;
        n_checks++; if (active !== 1'b0 || shape_size_x !== 10'd0 || shape_size_y !== 10'd0) $display("FAIL land_after got active=%b size=(%0d,%0d) want 0 (0,0)", active, shape_size_x, shape_size_y); else n_pass++;
        @(posedge Clk); #1;
        n_checks++; if (landed !== 1'b0) $display("FAIL land_pulse got %b want 0", landed); else n_pass++;
    endtask

    task automatic test_illegal();
        do_cmd(CMD_SPAWN, SHAPE_NONE);
        n_checks++; if (r_ok !== 1'b0 || active !== 1'b0) $display("FAIL spawn0 got ok=%b active=%b want 0 0", r_ok, active); else n_pass++;
        do_cmd(CMD_SPAWN, SHAPE_T);
        n_checks++; if (r_ok !== 1'b1 || shape_size_x !== 10'd48 || shape_size_y !== 10'd32) $display("FAIL spawn_t got ok=%b size=(%0d,%0d) want 1 (48,32)", r_ok, shape_size_x, shape_size_y); else n_pass++;
        do_cmd(CMD_SPAWN, SHAPE_I);
        n_checks++; if (r_ok !== 1'b0 || shape_num !== 3'd3 || pos_x_px !== 10'd48) $display("FAIL spawn_busy got ok=%b shape=%0d x=%0d want 0 3 48", r_ok, shape_num, pos_x_px); else n_pass++;
        do_cmd(CMD_ROT_CCW, 3'd0);
        n_checks++; if (shape_rot !== 2'd3 || shape_size_x !== 10'd32 || shape_size_y !== 10'd48) $display("FAIL ccw_wrap got rot=%0d size=(%0d,%0d) want 3 (32,48)", shape_rot, shape_size_x, shape_size_y); else n_pass++;
        do_cmd(CMD_ROT_CW, 3'd0);
        n_checks++; if (r_ok !== 1'b1 || shape_rot !== 2'd0) $display("FAIL cw_wrap got ok=%b rot=%0d want 1 0", r_ok, shape_rot); else n_pass++;
        do_cmd(CMD_CLEAR, 3'd0);
        do_cmd(CMD_LEFT, 3'd0);
        n_checks++; if ({r_vld, r_ok, r_land} !== 3'b100) $display("FAIL left_empty got vld/ok/landed=%b want 100", {r_vld, r_ok, r_land}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int rsps;
        do_cmd(CMD_SPAWN, SHAPE_S);
        rsps = 0;
        @(negedge Clk);
        cmd_valid = 1'b1; cmd_op = CMD_LEFT; cmd_shape = 3'd0;
        repeat (4) begin
            @(posedge Clk); #1;
            if (rsp_valid === 1'b1) rsps++;
        end
        cmd_valid = 1'b0;
        repeat (2) begin
            @(posedge Clk); #1;
            if (rsp_valid === 1'b1) rsps++;
        end
        n_checks++; if (rsps != 2) $display("FAIL b2b_rsps got %0d want 2", rsps); else n_pass++;
        n_checks++; if (pos_x_px !== 10'd16) $display("FAIL b2b_pos got %0d want 16", pos_x_px); else n_pass++;
    endtask

    task automatic test_reset_abort();
        @(negedge Clk);
        cmd_valid = 1'b1; cmd_op = CMD_RIGHT; cmd_shape = 3'd0;
        @(posedge Clk); #1;
        cmd_valid = 1'b0;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL abort_in_check got ready=%b want 0", cmd_ready); else n_pass++;
        #2 Reset_n = 1'b0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1 || active !== 1'b0 || shape_num !== 3'd0) $display("FAIL abort_state got ready=%b active=%b shape=%0d want 1 0 0", cmd_ready, active, shape_num); else n_pass++;
        n_checks++; if ({pos_x_px, pos_y_px, shape_size_x, shape_size_y} !== 40'd0) $display("FAIL abort_outputs got %h want 0", {pos_x_px, pos_y_px, shape_size_x, shape_size_y}); else n_pass++;
        @(negedge Clk); Reset_n = 1'b1;
        @(posedge Clk); #1;
        n_checks++; if (rsp_valid !== 1'b0 || pos_x_px !== 10'd0) $display("FAIL abort_no_rsp got vld=%b x=%0d want 0 0", rsp_valid, pos_x_px); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_right_edge();
        test_rotate_kick();
        test_drop_land();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
